smg_scan_ctrl: RTL and testbench
================================

# smg_scan_ctrl

Scan controller for the six-digit multiplexed seven-segment display. It owns the 1 ms digit timebase and rotates a one-hot digit state through all six digits. For each digit it drives an active-low strobe plus an active-low segment code decoded from a double-buffered 6×BCD display value. Game logic writes new scores through a load/ready handshake; values take effect only at frame boundaries (no tearing). A dead-time blank between digits suppresses ghosting.

## Interface
Parameters:
- TICK_MAX, 16'd49999, last count of the per-digit period (period = TICK_MAX+1 clk; 1 ms at 50 MHz); must be ≥ 2
- BLANK_CYC, 16'd16, dead-time cycles at the start of each digit period; must satisfy 1 ≤ BLANK_CYC ≤ TICK_MAX-1

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- load  in  1  request to write load_data into the pending buffer
- load_data  in  24  six BCD nibbles; [23:20] = digit0 (leftmost) … [3:0] = digit5 (rightmost)
- load_ready  out  1  pending buffer free; load accepted when load && load_ready at a rising edge
- lz_blank_en  in  1  leading-zero blanking enable (sampled every cycle)
- cur_state  out  6  one-hot digit state: IDLE=000001 (digit0), ST1=000010 … ST5=100000 (digit5)
- scan_sig  out  6  active-low digit strobe; digit k strobed when bit (5-k) is 0; 111111 = all off
- seg  out  8  active-low segments {dp,g,f,e,d,c,b,a}
- frame_done  out  1  one-cycle pulse at each frame wrap

## Operation
- Counter cnt (16 bit) increments each cycle and wraps to 0 after TICK_MAX. The wrap advances cur_state IDLE→ST1→…→ST5→IDLE.
- Decode for any state other than the six one-hot codes: next state IDLE, cnt 0.
- Strobes: IDLE 011111, ST1 101111, ST2 110111, ST3 111011, ST4 111101, ST5 111110.
- Blank window: while cnt < BLANK_CYC, scan_sig=111111 and seg=8'hFF. Otherwise scan_sig = strobe of cur_state and seg = decode of the current digit from the active buffer.
- Segment decode, BCD 0–9: C0, F9, A4, B0, 99, 92, 82, F8, 80, 90. Nibbles A–F decode to BF (dash). dp is always off.
- Leading-zero blanking (lz_blank_en=1): digit k (k ≤ 4) shows FF if its nibble and all nibbles of digits 0..k-1 are 0. Digit5 is never blanked.
- Handshake:
  - An accepted load writes the pending buffer and sets load_ready=0.
  - On the ST5→IDLE wrap edge with a pending value: active ← pending, and load_ready returns to 1 on that same edge.
  - A load while load_ready=0 is ignored, including a load in the commit cycle.
  - The active buffer changes only at frame wrap.
- frame_done=1 for the one cycle after every ST5→IDLE edge, whether or not a commit occurred.

## Timing
- All outputs are registered and update on the clk rising edge.
- Reset values: cnt 0, cur_state 000001, scan_sig 111111, seg FF, active buffer 0, pending buffer 0, load_ready 1, frame_done 0.
- rst_n low clears all state immediately, mid-digit included. The first strobe after release appears on the edge where cnt reaches BLANK_CYC.
- Digit period is TICK_MAX+1 cycles, with the strobe asserted for TICK_MAX+1-BLANK_CYC cycles. Frame = 6·(TICK_MAX+1) cycles.
- scan_sig and seg change on the same edge: both go to off/FF on the cnt→0 edge, and both go to strobe/code on the cnt→BLANK_CYC edge.
- Load-to-display latency: the value appears at digit0's strobe in the frame after the next ST5→IDLE wrap. Worst case ≈ 1 frame + BLANK_CYC.

## Test plan
All scenarios use TICK_MAX=9, BLANK_CYC=2.
- Reset: rst_n low → cur_state 000001, scan_sig 111111, seg FF, load_ready 1. After release, the 2nd edge gives scan_sig 011111, seg C0. Full frame = 60 cycles; frame_done pulses once per 60 cycles.
- Load 24'h123456 with lz off → after the next wrap, digits 0..5 show F9, A4, B0, 99, 92, 82 with strobes 011111…111110. Each digit shows 2 blanked cycles followed by 8 strobed cycles.
- lz on:
  - 24'h000405 → FF, FF, FF, 99, C0, 92.
  - 24'h000000 → FF×5, then C0.
  - lz off with 24'h000000 → C0×6.
- Handshake:
  - Load A mid-frame → load_ready 0.
  - Load B in the same frame → ignored.
  - Load C in the commit cycle → ignored.
  - After the wrap, the display shows A and load_ready=1.
- Invalid BCD 24'hA0F009 → BF, C0, BF, C0, C0, 90.
- Assert rst_n low at ST3 with cnt=5 → outputs return to reset values asynchronously, before the next edge, and the active buffer reads 0 (seg C0 at digit5 with lz off).

Source files
------------

// File: rtl/smg_scan_if.sv
// Display/handshake bundle between game logic (master) and the seven-segment scan controller
// (slave).
interface smg_scan_if;
  logic        load;
  logic [23:0] load_data;
  logic        load_ready;
  logic        lz_blank_en;
  logic [5:0]  cur_state;
  logic [5:0]  scan_sig;
  logic [7:0]  seg;
  logic        frame_done;

  modport master (
    output load, load_data, lz_blank_en,
    input  load_ready, cur_state, scan_sig, seg, frame_done
  );

  modport slave (
    input  load, load_data, lz_blank_en,
    output load_ready, cur_state, scan_sig, seg, frame_done
  );
endinterface

// File: rtl/smg_scan_ctrl.sv
// Six-digit multiplexed seven-segment scan controller with a double-buffered BCD value,
// frame-aligned commits, dead-time blanking and optional leading-zero suppression.
module smg_scan_ctrl #(
  parameter logic [15:0] TICK_MAX  = 16'd49999,
  parameter logic [15:0] BLANK_CYC = 16'd16
) (
  input logic        clk,
  input logic        rst_n,
  smg_scan_if.slave  bus
);

  typedef enum logic [5:0] {
    StIdle = 6'b000001,
    St1    = 6'b000010,
    St2    = 6'b000100,
    St3    = 6'b001000,
    St4    = 6'b010000,
    St5    = 6'b100000
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [23:0] active_q, active_d;
  logic [23:0] pending_q, pending_d;
  logic        load_ready_q, load_ready_d;
  logic        frame_done_q, frame_done_d;
  logic [5:0]  scan_q, scan_d;
  logic [7:0]  seg_q, seg_d;

  logic        tick_wrap;
  logic        frame_wrap;
  logic [2:0]  dig;
  logic [3:0]  nib;
  logic        lead_zero;
  logic [5:0]  strobe;

  function automatic logic [7:0] bcd_to_seg(input logic [3:0] v);
    case (v)
      4'd0:    return 8'hC0;
      4'd1:    return 8'hF9;
      4'd2:    return 8'hA4;
      4'd3:    return 8'hB0;
      4'd4:    return 8'h99;
      4'd5:    return 8'h92;
      4'd6:    return 8'h82;
      4'd7:    return 8'hF8;
      4'd8:    return 8'h80;
      4'd9:    return 8'h90;
      default: return 8'hBF;
    endcase
  endfunction

  always_comb begin
    tick_wrap    = (cnt_q >= TICK_MAX);
    frame_wrap   = 1'b0;
    state_d      = state_q;
    cnt_d        = tick_wrap ? 16'd0 : cnt_q + 16'd1;

    unique case (state_q)
      StIdle:  if (tick_wrap) state_d = St1;
      St1:     if (tick_wrap) state_d = St2;
      St2:     if (tick_wrap) state_d = St3;
      St3:     if (tick_wrap) state_d = St4;
      St4:     if (tick_wrap) state_d = St5;
      St5: begin
        if (tick_wrap) begin
          state_d    = StIdle;
          frame_wrap = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = 16'd0;
      end
    endcase

    // Commit takes priority; a load while the pending slot is full is dropped.
    active_d     = active_q;
    pending_d    = pending_q;
    load_ready_d = load_ready_q;
    if (frame_wrap && !load_ready_q) begin
      active_d     = pending_q;
      load_ready_d = 1'b1;
    end else if (bus.load && load_ready_q) begin
      pending_d    = bus.load_data;
      load_ready_d = 1'b0;
    end
    frame_done_d = frame_wrap;

    case (state_d)
      St1:     dig = 3'd1;
      St2:     dig = 3'd2;
      St3:     dig = 3'd3;
      St4:     dig = 3'd4;
      St5:     dig = 3'd5;
      default: dig = 3'd0;
    endcase

    nib       = active_d[23 - 4 * int'(dig) -: 4];
    lead_zero = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (k <= int'(dig) && active_d[23 - 4 * k -: 4] != 4'd0) lead_zero = 1'b0;
    end

    // Digit k is strobed by bit (5-k); the one-hot state is bit-reversed and inverted.
    strobe = 6'h3F;
    for (int i = 0; i < 6; i++) strobe[5 - i] = ~state_d[i];

    scan_d = 6'h3F;
    seg_d  = 8'hFF;
    if (cnt_d >= BLANK_CYC) begin
      scan_d = strobe;
      if (!(bus.lz_blank_en && lead_zero && dig != 3'd5)) seg_d = bcd_to_seg(nib);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      cnt_q        <= 16'd0;
      active_q     <= 24'd0;
      pending_q    <= 24'd0;
      load_ready_q <= 1'b1;
      frame_done_q <= 1'b0;
      scan_q       <= 6'h3F;
      seg_q        <= 8'hFF;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      active_q     <= active_d;
      pending_q    <= pending_d;
      load_ready_q <= load_ready_d;
      frame_done_q <= frame_done_d;
      scan_q       <= scan_d;
      seg_q        <= seg_d;
    end
  end

  assign bus.cur_state  = state_q;
  assign bus.scan_sig   = scan_q;
  assign bus.seg        = seg_q;
  assign bus.load_ready = load_ready_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_smg_scan_ctrl.sv
// Bench for smg_scan_ctrl with TICK_MAX=9, BLANK_CYC=2: directed loads, queued per-digit
// expectations checked by an independent strobe monitor.
module tb_smg_scan_ctrl;

  logic clk;
  logic rst_n;
  smg_scan_if bus();

  smg_scan_ctrl #(
    .TICK_MAX  (16'd9),
    .BLANK_CYC (16'd2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [5:0] scan;
    logic [7:0] seg;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Queue one frame of expected digits; segs = {digit0, ..., digit5}.
  task automatic push_frame(input logic [47:0] segs);
    exp_t e;
    logic [5:0] s;
    for (int k = 0; k < 6; k++) begin
      s = 6'b100000 >> k;
      e.scan = ~s;
      e.seg  = segs[47 - 8 * k -: 8];
      q.push_back(e);
    end
  endtask

  // Returns at the negedge where frame_done is seen (cnt 0, digit0 blank window).
  task automatic wait_frame();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.frame_done && n < 200);
    chk("frame_done_seen", {31'd0, bus.frame_done}, 32'd1);
  endtask

  task automatic do_load(input logic [23:0] v);
    bus.load      = 1'b1;
    bus.load_data = v;
    @(negedge clk);
    bus.load = 1'b0;
  endtask

  // Monitor: pops one expectation at each blank-to-strobe transition and checks the strobe
  // run length.
  initial begin
    logic [5:0] prev;
    exp_t       e;
    int         n;
    bit         run;
    prev = 6'h3F;
    forever begin
      @(negedge clk);
      if (bus.scan_sig != 6'h3F && prev == 6'h3F && q.size() > 0) begin
        e = q.pop_front();
        chk("digit_strobe", {26'd0, bus.scan_sig}, {26'd0, e.scan});
        chk("digit_seg", {24'd0, bus.seg}, {24'd0, e.seg});
        n   = 1;
        run = 1'b1;
        while (run && n < 30) begin
          @(negedge clk);
          if (bus.scan_sig == e.scan && bus.seg == e.seg) n++;
          else run = 1'b0;
        end
        chk("strobe_len", n, 8);
      end
      prev = bus.scan_sig;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n           = 1'b1;
    bus.load        = 1'b0;
    bus.load_data   = 24'd0;
    bus.lz_blank_en = 1'b0;
    #3 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_state", {26'd0, bus.cur_state}, 32'h01);
    chk("rst_scan", {26'd0, bus.scan_sig}, 32'h3F);
    chk("rst_seg", {24'd0, bus.seg}, 32'hFF);
    chk("rst_ready", {31'd0, bus.load_ready}, 32'd1);
    chk("rst_fdone", {31'd0, bus.frame_done}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("edge1_scan", {26'd0, bus.scan_sig}, 32'h3F);
    @(negedge clk);
    chk("edge2_scan", {26'd0, bus.scan_sig}, 32'h1F);
    chk("edge2_seg", {24'd0, bus.seg}, 32'hC0);

    wait_frame();
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.frame_done && n < 200);
    chk("frame_period", n, 60);
    chk("wrap_state", {26'd0, bus.cur_state}, 32'h01);

    // Zero value with lz off, then load 123456.
    push_frame({8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0});
    do_load(24'h123456);
    chk("ready_after_load", {31'd0, bus.load_ready}, 32'd0);
    wait_frame();
    chk("ready_after_commit", {31'd0, bus.load_ready}, 32'd1);
    push_frame({8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82});

    // Leading-zero blanking.
    bus.lz_blank_en = 1'b1;
    do_load(24'h000405);
    wait_frame();
    push_frame({8'hFF, 8'hFF, 8'hFF, 8'h99, 8'hC0, 8'h92});
    do_load(24'h000000);
    wait_frame();
    push_frame({8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hC0});
    wait_frame();
    bus.lz_blank_en = 1'b0;
    push_frame({8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0});

    // Handshake: A accepted, B dropped, C in the commit cycle dropped.
    wait_frame();
    push_frame({8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0});
    for (int c = 1; c <= 59; c++) begin
      @(negedge clk);
      if (c == 13) begin
        bus.load = 1'b1; bus.load_data = 24'h246801;
      end else if (c == 14) begin
        bus.load = 1'b0;
        chk("hs_ready_a", {31'd0, bus.load_ready}, 32'd0);
      end else if (c == 30) begin
        bus.load = 1'b1; bus.load_data = 24'h111111;
      end else if (c == 31) begin
        bus.load = 1'b0;
        chk("hs_ready_b", {31'd0, bus.load_ready}, 32'd0);
      end else if (c == 59) begin
        bus.load = 1'b1; bus.load_data = 24'h777777;
      end
    end
    @(negedge clk);
    bus.load = 1'b0;
    chk("hs_fdone", {31'd0, bus.frame_done}, 32'd1);
    chk("hs_ready_commit", {31'd0, bus.load_ready}, 32'd1);
    push_frame({8'hA4, 8'h99, 8'h82, 8'h80, 8'hC0, 8'hF9});
    wait_frame();
    push_frame({8'hA4, 8'h99, 8'h82, 8'h80, 8'hC0, 8'hF9});

    // Invalid BCD nibbles.
    do_load(24'hA0F009);
    wait_frame();
    push_frame({8'hBF, 8'hC0, 8'hBF, 8'hC0, 8'hC0, 8'h90});

    // Asynchronous reset at ST3, cnt=5.
    wait_frame();
    repeat (35) @(negedge clk);
    chk("pre_rst_state", {26'd0, bus.cur_state}, 32'h08);
    chk("pre_rst_scan", {26'd0, bus.scan_sig}, 32'h3B);
    chk("pre_rst_seg", {24'd0, bus.seg}, 32'hC0);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_state", {26'd0, bus.cur_state}, 32'h01);
    chk("arst_scan", {26'd0, bus.scan_sig}, 32'h3F);
    chk("arst_seg", {24'd0, bus.seg}, 32'hFF);
    chk("arst_ready", {31'd0, bus.load_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    push_frame({8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0});
    wait_frame();
    @(negedge clk);
    chk("queue_drained", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
